// File: rtl/mips32_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/ack, redirect/halt control,
// and the IF/ID valid/ready pair presented to decode.
interface mips32_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_ir, if_npc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, halt, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_ir, if_npc,
        output imem_ack, imem_rdata, redirect, redirect_pc, halt, if_ready
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction prefetch queue: one outstanding imem request, DEPTH-entry
// {ir, npc} FIFO towards decode, redirect flush with in-flight drop, halt gating.
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk1,
    input  logic                  rst,
    mips32_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state, state_n;
    logic [31:0]    pc, pc_n;
    logic           req_q, req_n;
    logic [31:0]    addr_q, addr_n;
    logic [31:0]    addr_inc;
    logic [31:0]    drop_target;
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_n;
    logic [63:0]    mem [DEPTH];
    logic           push, pop, flush;

    // Occupancy after this cycle's push/pop must stay below DEPTH to issue.
    function automatic logic has_space(input logic [CW-1:0] cnt,
                                       input logic psh, input logic pp);
        logic [CW:0] nxt;
        nxt = {1'b0, cnt} + {{CW{1'b0}}, psh} - {{CW{1'b0}}, pp};
        return nxt < DEPTH_V;
    endfunction

    assign addr_inc    = addr_q + 32'd1;
    assign drop_target = bus.redirect ? bus.redirect_pc : pc;
    assign pop         = bus.if_valid && bus.if_ready;

    always_comb begin
        state_n = state;
        req_n   = req_q;
        addr_n  = addr_q;
        pc_n    = pc;
        push    = 1'b0;
        flush   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    pc_n  = bus.redirect_pc;
                    if (!bus.halt) begin
                        state_n = REQ;
                        req_n   = 1'b1;
                        addr_n  = bus.redirect_pc;
                    end
                end else if (!bus.halt && has_space(count, 1'b0, pop)) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    pc_n  = bus.redirect_pc;
                    if (!bus.imem_ack) begin
                        // Request cannot be withdrawn; wait for it and throw it away.
                        state_n = DROP;
                    end else if (!bus.halt) begin
                        addr_n = bus.redirect_pc;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end else if (bus.imem_ack) begin
                    push = 1'b1;
                    pc_n = addr_inc;
                    if (!bus.halt && has_space(count, 1'b1, pop)) begin
                        addr_n = addr_inc;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                    pc_n  = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    if (!bus.halt && (flush || has_space(count, 1'b0, pop))) begin
                        state_n = REQ;
                        addr_n  = drop_target;
                    end else begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= 32'h0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            req_q  <= req_n;
            addr_q <= addr_n;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_n;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk1) begin
        if (push) mem[wr_ptr] <= {bus.imem_rdata, addr_inc};
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = (count != '0);
    assign bus.if_ir     = mem[rd_ptr][63:32];
    assign bus.if_npc    = mem[rd_ptr][31:0];
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue: directed scenarios push expected
// {ir, npc} pairs; a monitor pops and compares on every decode handshake.
module tb_mips32_fetch_queue;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic rst;
    logic rst2;

    mips32_fetch_queue_if bus ();
    mips32_fetch_queue_if bus2 ();

    mips32_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    mips32_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFF)) u_dut2 (
        .clk1 (clk1),
        .rst  (rst2),
        .bus  (bus2)
    );

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } item_t;

    int    n_cmp = 0;
    int    n_err = 0;
    item_t sb[$];
    item_t exp_item;
    int    ack_delay = 0;
    int    wait_cnt  = 0;

    // Second instance: memory acks every request immediately.
    assign bus2.imem_ack   = bus2.imem_req;
    assign bus2.imem_rdata = 32'h1000_0000 + bus2.imem_addr;

    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_item(input logic [31:0] ir, input logic [31:0] npc);
        sb.push_back({ir, npc});
    endtask

    // Memory model for the first instance: word k holds 0x1000_0000 + k,
    // ack arrives after ack_delay waiting cycles of a held request.
    always @(negedge clk1) begin
        if (bus.imem_req) begin
            if (wait_cnt >= ack_delay) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 32'h1000_0000 + bus.imem_addr;
                wait_cnt       = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
        end
    end

    // Decode-side monitor.
    always @(negedge clk1) begin
        #1;
        if (bus.if_valid && bus.if_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got ir=%h npc=%h, required no output",
                         bus.if_ir, bus.if_npc);
            end else begin
                exp_item = sb.pop_front();
                check32("if_ir", bus.if_ir, exp_item.ir);
                check32("if_npc", bus.if_npc, exp_item.npc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.halt = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.if_ready = 1'b0;
        bus2.halt = 1'b0;
        bus2.redirect = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.if_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check32("rst_req", bus.imem_req, 32'd0);
        check32("rst_addr", bus.imem_addr, 32'd0);
        check32("rst_valid", bus.if_valid, 32'd0);
        check32("rst2_req", bus2.imem_req, 32'd0);

        // Streaming: ack every cycle, decode always ready
        for (int k = 0; k < 8; k++) expect_item(32'h1000_0000 + k, k + 1);
        bus.if_ready = 1'b1;
        rst = 1'b0;
        tick();
        check32("t1_first_req", bus.imem_req, 32'd1);
        check32("t1_first_addr", bus.imem_addr, 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check32("t1_req_hold", bus.imem_req, 32'd1);
            check32("t1_valid_hold", bus.if_valid, 32'd1);
        end
        bus.halt = 1'b1;
        repeat (4) tick();
        check32("t1_drain", sb.size(), 32'd0);
        check32("t1_halt_req", bus.imem_req, 32'd0);

        // Fill to DEPTH with decode stalled, then one pop reopens fetch
        for (int k = 8; k < 13; k++) expect_item(32'h1000_0000 + k, k + 1);
        bus.if_ready = 1'b0;
        bus.halt = 1'b0;
        tick();
        check32("t2_resume_req", bus.imem_req, 32'd1);
        check32("t2_resume_addr", bus.imem_addr, 32'd8);
        repeat (4) tick();
        check32("t2_full_req", bus.imem_req, 32'd0);
        repeat (3) tick();
        check32("t2_full_req_hold", bus.imem_req, 32'd0);
        check32("t2_full_valid", bus.if_valid, 32'd1);
        bus.if_ready = 1'b1;
        tick();
        bus.if_ready = 1'b0;
        bus.halt = 1'b1;
        check32("t2_refill_req", bus.imem_req, 32'd1);
        check32("t2_refill_addr", bus.imem_addr, 32'd12);
        tick();
        bus.if_ready = 1'b1;
        repeat (6) tick();
        check32("t2_drain", sb.size(), 32'd0);
        check32("t2_idle_req", bus.imem_req, 32'd0);

        // Redirect while addr 2 waits for a delayed ack
        rst = 1'b1;
        bus.halt = 1'b0;
        ack_delay = 3;
        repeat (2) tick();
        expect_item(32'h1000_0000, 32'h1);
        expect_item(32'h1000_0001, 32'h2);
        expect_item(32'h1000_0040, 32'h41);
        rst = 1'b0;
        repeat (10) tick();
        check32("t3_pending_addr", bus.imem_addr, 32'd2);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        check32("t3_drop_req", bus.imem_req, 32'd1);
        check32("t3_drop_addr", bus.imem_addr, 32'd2);
        check32("t3_drop_valid", bus.if_valid, 32'd0);
        repeat (2) tick();
        check32("t3_target_req", bus.imem_req, 32'd1);
        check32("t3_target_addr", bus.imem_addr, 32'h40);
        bus.halt = 1'b1;
        repeat (8) tick();
        check32("t3_drain", sb.size(), 32'd0);
        check32("t3_idle_req", bus.imem_req, 32'd0);

        // Redirect coinciding with an ack and a pop
        rst = 1'b1;
        bus.halt = 1'b0;
        ack_delay = 0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) expect_item(32'h1000_0000 + k, k + 1);
        expect_item(32'h1000_0080, 32'h81);
        rst = 1'b0;
        repeat (5) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 1'b0;
        bus.halt = 1'b1;
        check32("t4_flush_valid", bus.if_valid, 32'd0);
        check32("t4_target_req", bus.imem_req, 32'd1);
        check32("t4_target_addr", bus.imem_addr, 32'h80);
        repeat (5) tick();
        check32("t4_drain", sb.size(), 32'd0);

        // Halt raised while a delayed request is outstanding
        rst = 1'b1;
        bus.halt = 1'b0;
        ack_delay = 2;
        repeat (2) tick();
        expect_item(32'h1000_0000, 32'h1);
        expect_item(32'h1000_0001, 32'h2);
        expect_item(32'h1000_0002, 32'h3);
        rst = 1'b0;
        repeat (4) tick();
        check32("t5_pending_req", bus.imem_req, 32'd1);
        check32("t5_pending_addr", bus.imem_addr, 32'd1);
        bus.halt = 1'b1;
        repeat (3) tick();
        check32("t5_halt_req", bus.imem_req, 32'd0);
        repeat (3) tick();
        check32("t5_halt_req_hold", bus.imem_req, 32'd0);
        check32("t5_halt_valid", bus.if_valid, 32'd0);
        bus.halt = 1'b0;
        tick();
        check32("t5_resume_req", bus.imem_req, 32'd1);
        check32("t5_resume_addr", bus.imem_addr, 32'd2);
        bus.halt = 1'b1;
        repeat (6) tick();
        check32("t5_drain", sb.size(), 32'd0);

        // Address wrap from RESET_PC = 0xFFFFFFFF, then reset mid-stream
        rst2 = 1'b0;
        tick();
        check32("t6_first_req", bus2.imem_req, 32'd1);
        check32("t6_first_addr", bus2.imem_addr, 32'hFFFF_FFFF);
        tick();
        check32("t6_valid", bus2.if_valid, 32'd1);
        check32("t6_ir", bus2.if_ir, 32'h0FFF_FFFF);
        check32("t6_npc", bus2.if_npc, 32'h0);
        check32("t6_second_addr", bus2.imem_addr, 32'h0);
        rst2 = 1'b1;
        tick();
        check32("t6_rst_valid", bus2.if_valid, 32'd0);
        check32("t6_rst_req", bus2.imem_req, 32'd0);
        check32("t6_rst_addr", bus2.imem_addr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
